// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter sharing one backing memory port
module mem_arbiter #(
    parameter logic rr_enable = 1'b1,
    parameter logic data_prio = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_in_mem_valid,
    input  logic        ibus_in_mem_fence,
    input  logic        ibus_in_mem_instr,
    input  logic [31:0] ibus_in_mem_addr,
    input  logic [31:0] ibus_in_mem_wdata,
    input  logic [3:0]  ibus_in_mem_wstrb,
    output logic [31:0] ibus_out_mem_rdata,
    output logic        ibus_out_mem_ready,
    input  logic        dbus_in_mem_valid,
    input  logic        dbus_in_mem_fence,
    input  logic        dbus_in_mem_instr,
    input  logic [31:0] dbus_in_mem_addr,
    input  logic [31:0] dbus_in_mem_wdata,
    input  logic [3:0]  dbus_in_mem_wstrb,
    output logic [31:0] dbus_out_mem_rdata,
    output logic        dbus_out_mem_ready,
    output logic        mem_in_mem_valid,
    output logic        mem_in_mem_fence,
    output logic        mem_in_mem_instr,
    output logic [31:0] mem_in_mem_addr,
    output logic [31:0] mem_in_mem_wdata,
    output logic [3:0]  mem_in_mem_wstrb,
    input  logic        mem_out_mem_ready,
    input  logic [31:0] mem_out_mem_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        fence;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t state, state_nxt;
    req_t   i_slot, d_slot, issued, sel;
    logic   i_pend, d_pend;
    logic   owner;       // 0 = instruction side, 1 = data side
    logic   last_grant;
    logic   i_done, d_done, i_free, d_free, i_cap, d_cap;
    logic   issue, grant_d;

    assign i_done = (state == BUSY) && !owner && mem_out_mem_ready;
    assign d_done = (state == BUSY) &&  owner && mem_out_mem_ready;

    // The owner's slot reopens in its ready cycle so a held-valid burst keeps streaming.
    assign i_free = (!i_pend && !((state == BUSY) && !owner)) || i_done;
    assign d_free = (!d_pend && !((state == BUSY) &&  owner)) || d_done;
    assign i_cap  = ibus_in_mem_valid && i_free;
    assign d_cap  = dbus_in_mem_valid && d_free;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        grant_d   = 1'b0;
        sel       = i_slot;
        sel.instr = 1'b1;
        if (i_pend && d_pend)
            grant_d = rr_enable ? !last_grant : data_prio;
        else
            grant_d = d_pend;
        if (grant_d)
            sel = d_slot;
        case (state)
            IDLE: begin
                if (i_pend || d_pend) begin
                    issue     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_out_mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            i_pend     <= 1'b0;
            d_pend     <= 1'b0;
            i_slot     <= '0;
            d_slot     <= '0;
            issued     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (issue) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                issued     <= sel;
            end
            if (i_cap) begin
                i_pend <= 1'b1;
                i_slot <= '{ibus_in_mem_fence, ibus_in_mem_instr, ibus_in_mem_addr,
                            ibus_in_mem_wdata, ibus_in_mem_wstrb};
            end else if (issue && !grant_d) begin
                i_pend <= 1'b0;
            end
            if (d_cap) begin
                d_pend <= 1'b1;
                d_slot <= '{dbus_in_mem_fence, dbus_in_mem_instr, dbus_in_mem_addr,
                            dbus_in_mem_wdata, dbus_in_mem_wstrb};
            end else if (issue && grant_d) begin
                d_pend <= 1'b0;
            end
        end
    end

    // Downstream fields show the winner during the issue pulse, then hold what was issued.
    assign mem_in_mem_valid = issue;
    assign mem_in_mem_fence = issue ? sel.fence : issued.fence;
    assign mem_in_mem_instr = issue ? sel.instr : issued.instr;
    assign mem_in_mem_addr  = issue ? sel.addr  : issued.addr;
    assign mem_in_mem_wdata = issue ? sel.wdata : issued.wdata;
    assign mem_in_mem_wstrb = issue ? sel.wstrb : issued.wstrb;

    assign ibus_out_mem_ready = i_done;
    assign ibus_out_mem_rdata = i_done ? mem_out_mem_rdata : 32'h0;
    assign dbus_out_mem_ready = d_done;
    assign dbus_out_mem_rdata = d_done ? mem_out_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        i_v, i_f, i_ins, d_v, d_f, d_ins, m_v, m_f, m_ins, m_rdy;
    logic [31:0] i_a, i_w, d_a, d_w, m_a, m_w, m_rd, i_rd, d_rd;
    logic [3:0]  i_s, d_s, m_s;
    logic        i_rdy, d_rdy;

    logic        fp_i_v, fp_d_v, fp_m_v, fp_m_f, fp_m_ins, fp_m_rdy, fp_i_rdy, fp_d_rdy;
    logic [31:0] fp_i_a, fp_d_a, fp_m_a, fp_m_w, fp_m_rd, fp_i_rd, fp_d_rd;
    logic [3:0]  fp_m_s;

    mem_arbiter #(.rr_enable(1'b1), .data_prio(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ibus_in_mem_valid(i_v), .ibus_in_mem_fence(i_f), .ibus_in_mem_instr(i_ins),
        .ibus_in_mem_addr(i_a), .ibus_in_mem_wdata(i_w), .ibus_in_mem_wstrb(i_s),
        .ibus_out_mem_rdata(i_rd), .ibus_out_mem_ready(i_rdy),
        .dbus_in_mem_valid(d_v), .dbus_in_mem_fence(d_f), .dbus_in_mem_instr(d_ins),
        .dbus_in_mem_addr(d_a), .dbus_in_mem_wdata(d_w), .dbus_in_mem_wstrb(d_s),
        .dbus_out_mem_rdata(d_rd), .dbus_out_mem_ready(d_rdy),
        .mem_in_mem_valid(m_v), .mem_in_mem_fence(m_f), .mem_in_mem_instr(m_ins),
        .mem_in_mem_addr(m_a), .mem_in_mem_wdata(m_w), .mem_in_mem_wstrb(m_s),
        .mem_out_mem_ready(m_rdy), .mem_out_mem_rdata(m_rd)
    );

    mem_arbiter #(.rr_enable(1'b0), .data_prio(1'b1)) fp_dut (
        .clk(clk), .rst(rst),
        .ibus_in_mem_valid(fp_i_v), .ibus_in_mem_fence(1'b0), .ibus_in_mem_instr(1'b0),
        .ibus_in_mem_addr(fp_i_a), .ibus_in_mem_wdata(32'h0), .ibus_in_mem_wstrb(4'h0),
        .ibus_out_mem_rdata(fp_i_rd), .ibus_out_mem_ready(fp_i_rdy),
        .dbus_in_mem_valid(fp_d_v), .dbus_in_mem_fence(1'b0), .dbus_in_mem_instr(1'b0),
        .dbus_in_mem_addr(fp_d_a), .dbus_in_mem_wdata(32'h0), .dbus_in_mem_wstrb(4'h0),
        .dbus_out_mem_rdata(fp_d_rd), .dbus_out_mem_ready(fp_d_rdy),
        .mem_in_mem_valid(fp_m_v), .mem_in_mem_fence(fp_m_f), .mem_in_mem_instr(fp_m_ins),
        .mem_in_mem_addr(fp_m_a), .mem_in_mem_wdata(fp_m_w), .mem_in_mem_wstrb(fp_m_s),
        .mem_out_mem_ready(fp_m_rdy), .mem_out_mem_rdata(fp_m_rd)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_resp = 1'b1;
    bit fp_mon = 1'b0;
    int fp_grants = 0, fp_igrants = 0, fp_iresp = 0;

    typedef struct {
        logic        fence;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } iss_t;

    typedef struct {
        bit          iv;
        bit          dv;
        bit          i_first;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
    } vec_t;

    iss_t        iss_q[$];
    logic [31:0] ir_q[$];
    logic [31:0] dr_q[$];
    vec_t        vecs[6];

    function automatic logic [31:0] fmem(logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_issue(bit d, logic [31:0] a, logic f, logic [31:0] w, logic [3:0] s, int c);
        iss_t e;
        e.fence = f; e.instr = !d; e.addr = a; e.wdata = w; e.wstrb = s; e.cyc = c;
        iss_q.push_back(e);
    endtask

    task automatic exp_txn(bit d, logic [31:0] a, logic f, logic [31:0] w, logic [3:0] s, int c);
        exp_issue(d, a, f, w, s, c);
        if (d) dr_q.push_back(fmem(a));
        else   ir_q.push_back(fmem(a));
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((iss_q.size() != 0 || ir_q.size() != 0 || dr_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (iss_q.size() != 0 || ir_q.size() != 0 || dr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending issue=%0d iresp=%0d dresp=%0d expected=0",
                     name, iss_q.size(), ir_q.size(), dr_q.size());
            iss_q.delete(); ir_q.delete(); dr_q.delete();
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: answer one cycle after each valid pulse.
    always begin : resp
        logic v;
        logic [31:0] a;
        @(negedge clk);
        v = m_v; a = m_a;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            m_rdy = v;
            m_rd  = v ? fmem(a) : 32'h0;
        end
    end

    always begin : fp_resp
        logic v;
        logic [31:0] a;
        @(negedge clk);
        v = fp_m_v; a = fp_m_a;
        @(posedge clk);
        #1;
        fp_m_rdy = v;
        fp_m_rd  = v ? fmem(a) : 32'h0;
    end

    always @(negedge clk) begin : monitor
        iss_t e;
        logic [31:0] r;
        if (rst) begin
            if (m_v) begin
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue addr=%h expected=no_issue", m_a);
                end else begin
                    e = iss_q.pop_front();
                    check("issue_addr", m_a, e.addr);
                    check("issue_fence", {31'h0, m_f}, {31'h0, e.fence});
                    check("issue_instr", {31'h0, m_ins}, {31'h0, e.instr});
                    check("issue_wdata", m_w, e.wdata);
                    check("issue_wstrb", {28'h0, m_s}, {28'h0, e.wstrb});
                    if (e.cyc >= 0) check("issue_cycle", cyc, e.cyc);
                end
            end
            if (i_rdy) begin
                if (ir_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_iready rdata=%h expected=no_ready", i_rd);
                end else begin
                    r = ir_q.pop_front();
                    check("iresp_rdata", i_rd, r);
                end
            end
            if (d_rdy) begin
                if (dr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_dready rdata=%h expected=no_ready", d_rd);
                end else begin
                    r = dr_q.pop_front();
                    check("dresp_rdata", d_rd, r);
                end
            end
            if (!i_rdy && i_rd != 32'h0) check("idle_irdata", i_rd, 32'h0);
            if (!d_rdy && d_rd != 32'h0) check("idle_drdata", d_rd, 32'h0);
        end
        if (rst && fp_mon) begin
            if (fp_m_v) begin
                fp_grants++;
                if (fp_m_ins) fp_igrants++;
            end
            if (fp_i_rdy) fp_iresp++;
        end
    end

    initial begin
        int t;
        int k;
        i_v = 0; i_f = 0; i_ins = 0; i_a = 0; i_w = 0; i_s = 0;
        d_v = 0; d_f = 0; d_ins = 0; d_a = 0; d_w = 0; d_s = 0;
        m_rdy = 0; m_rd = 0;
        fp_i_v = 0; fp_d_v = 0; fp_i_a = 0; fp_d_a = 0;

        vecs[0] = '{iv: 1, dv: 1, i_first: 1, ia: 32'h0000_0200, da: 32'h8000_0000, dw: 32'h0, ds: 4'h0};
        vecs[1] = '{iv: 1, dv: 1, i_first: 1, ia: 32'h0000_0204, da: 32'h8000_0004, dw: 32'hCAFE_0001, ds: 4'h3};
        vecs[2] = '{iv: 1, dv: 0, i_first: 1, ia: 32'h0000_0208, da: 32'h0, dw: 32'h0, ds: 4'h0};
        vecs[3] = '{iv: 1, dv: 1, i_first: 0, ia: 32'h0000_020C, da: 32'h8000_0008, dw: 32'h0, ds: 4'h0};
        vecs[4] = '{iv: 0, dv: 1, i_first: 0, ia: 32'h0, da: 32'h8000_000C, dw: 32'h5555_AAAA, ds: 4'hF};
        vecs[5] = '{iv: 1, dv: 1, i_first: 1, ia: 32'h0000_0210, da: 32'h8000_0010, dw: 32'h0, ds: 4'h0};

        repeat (3) @(posedge clk);
        #2;
        check("rst_mem_valid", {31'h0, m_v}, 32'h0);
        check("rst_mem_fence", {31'h0, m_f}, 32'h0);
        check("rst_mem_instr", {31'h0, m_ins}, 32'h0);
        check("rst_mem_addr", m_a, 32'h0);
        check("rst_mem_wdata", m_w, 32'h0);
        check("rst_mem_wstrb", {28'h0, m_s}, 32'h0);
        check("rst_iready", {31'h0, i_rdy}, 32'h0);
        check("rst_irdata", i_rd, 32'h0);
        check("rst_dready", {31'h0, d_rdy}, 32'h0);
        check("rst_drdata", d_rd, 32'h0);
        rst = 1;

        // Round-robin table: I wins the first tie after reset, then grants depend on last_grant.
        for (int v = 0; v < 6; v++) begin
            tick();
            i_v = vecs[v].iv; i_a = vecs[v].ia;
            d_v = vecs[v].dv; d_a = vecs[v].da; d_w = vecs[v].dw; d_s = vecs[v].ds;
            t = cyc;
            if (vecs[v].iv && vecs[v].dv) begin
                if (vecs[v].i_first) begin
                    exp_txn(0, vecs[v].ia, 0, 32'h0, 4'h0, t + 1);
                    exp_txn(1, vecs[v].da, 0, vecs[v].dw, vecs[v].ds, t + 3);
                end else begin
                    exp_txn(1, vecs[v].da, 0, vecs[v].dw, vecs[v].ds, t + 1);
                    exp_txn(0, vecs[v].ia, 0, 32'h0, 4'h0, t + 3);
                end
            end else if (vecs[v].iv) begin
                exp_txn(0, vecs[v].ia, 0, 32'h0, 4'h0, t + 1);
            end else begin
                exp_txn(1, vecs[v].da, 0, vecs[v].dw, vecs[v].ds, t + 1);
            end
            tick();
            i_v = 0; d_v = 0; d_w = 0; d_s = 0;
            drain("vector");
        end

        // Single fetch with a slow memory answering three cycles after the request.
        auto_resp = 0;
        tick();
        m_rdy = 0; m_rd = 0;
        tick();
        i_v = 1; i_a = 32'h0000_0100;
        t = cyc;
        exp_issue(0, 32'h0000_0100, 0, 32'h0, 4'h0, t + 1);
        ir_q.push_back(32'hDEAD_BEEF);
        tick();
        i_v = 0;
        tick();
        tick();
        m_rdy = 1; m_rd = 32'hDEAD_BEEF;
        #1;
        check("fetch_iready", {31'h0, i_rdy}, 32'h1);
        check("fetch_dready", {31'h0, d_rdy}, 32'h0);
        tick();
        m_rdy = 0; m_rd = 0;
        auto_resp = 1;
        drain("fetch");

        // Held-valid burst, advancing the address in each ready cycle.
        tick();
        i_v = 1; i_a = 32'h0000_0300;
        t = cyc;
        for (int j = 0; j < 4; j++)
            exp_txn(0, 32'h0000_0300 + 32'(4 * j), 0, 32'h0, 4'h0, t + 1 + 2 * j);
        k = 0;
        for (int n = 0; n < 60 && k < 4; n++) begin
            tick();
            #1;
            if (i_rdy) begin
                k++;
                if (k < 4) i_a = 32'h0000_0300 + 32'(4 * k);
                else       i_v = 0;
            end
        end
        check("burst_count", k, 4);
        i_v = 0;
        drain("burst");

        // Fence in flight, data write arrives behind it.
        tick();
        i_v = 1; i_f = 1; i_a = 32'h0000_0040;
        t = cyc;
        exp_txn(0, 32'h0000_0040, 1, 32'h0, 4'h0, t + 1);
        tick();
        i_v = 0; i_f = 0;
        d_v = 1; d_a = 32'h0000_0010; d_w = 32'h1234_5678; d_s = 4'hF;
        exp_txn(1, 32'h0000_0010, 0, 32'h1234_5678, 4'hF, t + 3);
        tick();
        d_v = 0; d_w = 0; d_s = 0;
        drain("fence");

        // Reset while busy; a late ready must not be forwarded.
        auto_resp = 0;
        tick();
        m_rdy = 0; m_rd = 0;
        tick();
        i_v = 1; i_a = 32'h0000_0500;
        t = cyc;
        exp_issue(0, 32'h0000_0500, 0, 32'h0, 4'h0, t + 1);
        tick();
        i_v = 0;
        tick();
        rst = 0;
        tick();
        rst = 1;
        #1;
        check("rstmid_mem_valid", {31'h0, m_v}, 32'h0);
        check("rstmid_mem_addr", m_a, 32'h0);
        check("rstmid_mem_instr", {31'h0, m_ins}, 32'h0);
        m_rdy = 1; m_rd = 32'h1111_1111;
        #1;
        check("rstmid_iready", {31'h0, i_rdy}, 32'h0);
        check("rstmid_irdata", i_rd, 32'h0);
        tick();
        m_rdy = 0; m_rd = 0;
        repeat (4) tick();
        check("rstmid_pending", iss_q.size(), 0);
        auto_resp = 1;
        tick();
        tick();
        i_v = 1; d_v = 1; i_a = 32'h0000_0600; d_a = 32'h8000_0600;
        t = cyc;
        exp_txn(0, 32'h0000_0600, 0, 32'h0, 4'h0, t + 1);
        exp_txn(1, 32'h8000_0600, 0, 32'h0, 4'h0, t + 3);
        tick();
        i_v = 0; d_v = 0;
        drain("after_reset");

        // Fixed priority, data side preferred: instruction side starves while data keeps asking.
        fp_mon = 1;
        tick();
        fp_i_v = 1; fp_i_a = 32'h0000_0700;
        fp_d_v = 1; fp_d_a = 32'h8000_0700;
        repeat (20) tick();
        check("fp_igrants_starved", fp_igrants, 0);
        check("fp_iresp_starved", fp_iresp, 0);
        check("fp_dgrants_enough", {31'h0, fp_grants >= 9}, 32'h1);
        fp_i_v = 0; fp_d_v = 0;
        repeat (8) tick();
        check("fp_igrant_after", fp_igrants, 1);
        check("fp_iresp_after", fp_iresp, 1);

        drain("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one backing memory port between two requesters:
  - the instruction side, i.e. the ITIM refill/bypass port (imem_in/imem_out of the ITIM);
  - the data side (data memory / DTIM refill port).
- Holds one request slot per requester, picks the next request by fixed priority or round-robin, and issues it downstream as a single-cycle valid pulse.
- Routes the downstream ready/rdata back to the requester that owns the outstanding transaction.
- Sits between the ITIM/data-side controllers and the shared memory/interconnect.

Parameters:
- rr_enable, 1, 1 = round-robin on simultaneous pending requests; 0 = fixed priority.
- data_prio, 1, fixed-priority mode only: 1 = data side wins ties, 0 = instruction side wins.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- ibus_in  input  mem_in_type  instruction-side request (valid, fence, instr, addr, wdata, wstrb)
- ibus_out  output  mem_out_type  instruction-side response (rdata, ready)
- dbus_in  input  mem_in_type  data-side request
- dbus_out  output  mem_out_type  data-side response
- mem_in  output  mem_in_type  request to backing memory
- mem_out  input  mem_out_type  response from backing memory

Behaviour:
- Reset (rst=0 at posedge clk): clear both slots, state=IDLE, last_grant=data (so the instruction side wins the first round-robin tie).
  - mem_in all fields 0; ibus_out/dbus_out rdata=0, ready=0.
  - Reset mid-transaction drops the outstanding request; a mem_out.mem_ready arriving afterwards while IDLE is ignored and not forwarded.
- Slots: per side, a registered copy of {fence, instr, addr, wdata, wstrb} plus a pend bit.
  - A request is captured when x_in.mem_valid=1 and the side's slot is free.
  - A slot is free when pend=0 and the side is not owner of the in-flight transaction, OR in the cycle the owner's response ready is delivered. This allows back-to-back requests with valid held high, e.g. ITIM burst refill presenting addr+4 in the ready cycle.
  - mem_valid held high while the side's slot is occupied is ignored (no duplicate capture).
  - Captured fields are frozen; later changes on x_in are ignored until the next capture.
- State machine:
  - IDLE:
    - If any pend=1, select a winner: rr_enable=1 → the side other than last_grant when both pend; else data_prio decides.
    - Drive mem_in from the winner's slot with mem_valid=1 for exactly this one cycle; mem_instr=1 for the instruction side regardless of the slot value.
    - Clear the winner's pend, set owner=winner and last_grant=winner, go to BUSY.
    - Earliest issue is the cycle after capture (capture→issue latency 1 cycle).
  - BUSY:
    - mem_in.mem_valid=0; other mem_in fields hold the issued values.
    - When mem_out.mem_ready=1: drive owner's x_out.rdata=mem_out.mem_rdata and x_out.ready=1 combinationally in the same cycle; go to IDLE.
    - A slot captured in that same cycle is issuable the next cycle.
    - No timeout; BUSY persists until ready or reset.
- Non-owner x_out: ready=0, rdata=0 at all times.
- Fence requests (mem_fence=1) are arbitrated and forwarded like any other request; the response is returned to the issuing side only.
- Simultaneous capture on both sides in one cycle: both slots fill; arbitration applies at the next IDLE cycle.
- Back-to-back: with both sides continuously requesting and rr_enable=1, grants alternate I, D, I, D.
- Throughput: one transaction per 2 cycles minimum (issue cycle plus ready cycle, with memory ready 1 cycle after valid).
- At most one outstanding downstream transaction; no reordering.

Test Plan:
- Single instruction fetch:
  - Stimulus: ibus_in valid=1 addr=0x0000_0100 for one cycle at T; memory returns ready=1, rdata=0xDEAD_BEEF at T+3.
  - Response: mem_in.valid=1 with addr=0x100, instr=1 at T+1 only; ibus_out.ready=1, rdata=0xDEADBEEF at T+3; dbus_out.ready=0 throughout.
- Simultaneous requests, rr_enable=1, after reset:
  - Stimulus: ibus addr=0x200 and dbus addr=0x8000_0000 valid in the same cycle T; memory ready 1 cycle after each valid.
  - Response: I issued at T+1, D issued at T+3; responses routed to the correct sides.
- Fixed priority (rr_enable=0, data_prio=1):
  - Stimulus: both sides hold valid high continuously.
  - Response: data side granted every time; instruction slot stays pending (starvation is the expected behaviour).
- Held-valid burst:
  - Stimulus: ibus valid held high, addr presented 0x300, 0x304, 0x308, 0x30C, each advancing in the ready cycle; valid=0 in the final ready cycle.
  - Response: exactly 4 downstream pulses with those addresses; no duplicate issue.
- Fence plus data write:
  - Stimulus: ibus fence=1 valid, then dbus valid addr=0x10 wdata=0x1234_5678 wstrb=0xF while the fence is in flight.
  - Response: fence forwarded with mem_fence=1; write issued only after the fence's ready; each ready goes only to its issuer.
- Reset mid-transaction:
  - Stimulus: rst=0 while BUSY, rst=1 next cycle, then memory asserts ready.
  - Response: all outputs 0, no x_out.ready pulse, state IDLE, slots empty.
